rv32_csr_host_port: RTL and testbench

RV32_CSR_HOST_PORT -- requirements
Module: rv32_csr_host_port

---
 rtl/rv32_csr_host_port.sv | 156 +++++++++++++++
 tb/tb_rv32_csr_host_port.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_csr_host_port.sv
// rv32_csr_host_port
//   Host-side access port onto the RV32 CSR file. Accepts one command at a
//   time (read / write / set bits / clear bits), waits for a cycle in which
//   the pipeline does not own the CSR port, performs one combined
//   read-modify-write access and returns the pre-access CSR value.
//
//   Optional feature (macro RV32_CSR_HOST_PORT_VERIFY_EN, default undefined):
//   after every modifying access, a second read-only access compares the
//   CSR against the value that should have been written. A mismatch is
//   reported as error 2'b10 (e.g. WARL fields that ignored some bits).
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   cmd_valid_in/ready_out  command handshake; op/csr/data captured on accept
//   cmd_op_in               00 read, 01 write, 10 set bits, 11 clear bits
//   rsp_valid_out/ready_in  response handshake
//   rsp_data_out            CSR value before the access (0 on violation)
//   rsp_error_out           00 ok, 01 read-only violation, 10 verify mismatch
//   csr_busy_in             pipeline owns the CSR port this cycle
//   csr_*_out               drive the CSR file's access port
//   csr_read_value_in       read data from the CSR file
module rv32_csr_host_port (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [1:0]  cmd_op_in,
  input  logic [11:0] cmd_csr_in,
  input  logic [31:0] cmd_data_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_data_out,
  output logic [1:0]  rsp_error_out,
  input  logic        csr_busy_in,
  output logic        csr_read_out,
  output logic        csr_write_out,
  output logic [1:0]  csr_write_op_out,
  output logic        csr_src_out,
  output logic [11:0] csr_out,
  output logic [31:0] csr_rs1_value_out,
  output logic [31:0] csr_imm_value_out,
  input  logic [31:0] csr_read_value_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, VERIFY, RESP} state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [11:0] csr_q;
  logic [31:0] data_q;
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_err_q;

  logic accept;
  logic ro_viol;
  logic issue_go;

  assign accept   = cmd_valid_in && cmd_ready_out;
  // Address space 0xC00-0xFFF is read-only; only modifying ops violate it.
  assign ro_viol  = (cmd_op_in != OP_READ) && (cmd_csr_in[11:10] == 2'b11);
  assign issue_go = (state_q == ISSUE) && !csr_busy_in;

`ifdef RV32_CSR_HOST_PORT_VERIFY_EN
  logic        verify_go;
  logic [31:0] expect_val;

  assign verify_go = (state_q == VERIFY) && !csr_busy_in;

  // rsp_data_q still holds the pre-access value captured in ISSUE.
  always_comb begin
    expect_val = data_q;
    case (op_q)
      OP_SET:  expect_val = rsp_data_q | data_q;
      OP_CLR:  expect_val = rsp_data_q & ~data_q;
      default: expect_val = data_q;
    endcase
  end
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = ro_viol ? RESP : ISSUE;
`ifdef RV32_CSR_HOST_PORT_VERIFY_EN
      ISSUE:  if (!csr_busy_in) state_d = (op_q != OP_READ) ? VERIFY : RESP;
      VERIFY: if (!csr_busy_in) state_d = RESP;
`else
      ISSUE:  if (!csr_busy_in) state_d = RESP;
`endif
      RESP:   if (rsp_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: purely from state and csr_busy_in, so strobes drop the instant
  // reset asserts (state is forced to IDLE asynchronously).
  always_comb begin
    cmd_ready_out = (state_q == IDLE) && reset_n;
    rsp_valid_out = (state_q == RESP);
    csr_read_out  = issue_go;
    csr_write_out = issue_go && (op_q != OP_READ);
`ifdef RV32_CSR_HOST_PORT_VERIFY_EN
    csr_read_out  = issue_go || verify_go;
`endif
    // Host op 01/10/11 maps onto CSR file op 00/01/10; reads use 00.
    csr_write_op_out  = (op_q == OP_READ) ? 2'b00 : (op_q - 2'd1);
    csr_src_out       = 1'b1;
    csr_out           = csr_q;
    csr_rs1_value_out = data_q;
    csr_imm_value_out = 32'd0;
    rsp_data_out      = rsp_data_q;
    rsp_error_out     = rsp_err_q;
  end

  // Command capture and response data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_READ;
      csr_q      <= 12'd0;
      data_q     <= 32'd0;
      rsp_data_q <= 32'd0;
      rsp_err_q  <= 2'b00;
    end else begin
      if (accept) begin
        op_q   <= cmd_op_in;
        csr_q  <= cmd_csr_in;
        data_q <= cmd_data_in;
        if (ro_viol) begin
          rsp_data_q <= 32'd0;
          rsp_err_q  <= 2'b01;
        end
      end
      if (issue_go) begin
        rsp_data_q <= csr_read_value_in;
        rsp_err_q  <= 2'b00;
      end
`ifdef RV32_CSR_HOST_PORT_VERIFY_EN
      if (verify_go)
        rsp_err_q <= (csr_read_value_in != expect_val) ? 2'b10 : 2'b00;
`endif
    end
  end

endmodule

// File: tb/tb_rv32_csr_host_port.sv
// Testbench for rv32_csr_host_port: a small CSR file stub answers the port;
// a transaction-level model predicts every response, strobe and file update.
module tb_rv32_csr_host_port;

`ifdef RV32_CSR_HOST_PORT_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid_in = 1'b0;
  logic        cmd_ready_out;
  logic [1:0]  cmd_op_in = 2'b00;
  logic [11:0] cmd_csr_in = 12'd0;
  logic [31:0] cmd_data_in = 32'd0;
  logic        rsp_valid_out;
  logic        rsp_ready_in = 1'b0;
  logic [31:0] rsp_data_out;
  logic [1:0]  rsp_error_out;
  logic        csr_busy_in = 1'b0;
  logic        csr_read_out;
  logic        csr_write_out;
  logic [1:0]  csr_write_op_out;
  logic        csr_src_out;
  logic [11:0] csr_out;
  logic [31:0] csr_rs1_value_out;
  logic [31:0] csr_imm_value_out;
  logic [31:0] csr_read_value_in;

  rv32_csr_host_port dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_op_in(cmd_op_in), .cmd_csr_in(cmd_csr_in), .cmd_data_in(cmd_data_in),
    .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
    .rsp_data_out(rsp_data_out), .rsp_error_out(rsp_error_out),
    .csr_busy_in(csr_busy_in), .csr_read_out(csr_read_out),
    .csr_write_out(csr_write_out), .csr_write_op_out(csr_write_op_out),
    .csr_src_out(csr_src_out), .csr_out(csr_out),
    .csr_rs1_value_out(csr_rs1_value_out), .csr_imm_value_out(csr_imm_value_out),
    .csr_read_value_in(csr_read_value_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // mtvec bit 1 is hard-wired to zero in the file stub (WARL).
  function automatic logic [31:0] warl(input logic [11:0] a, input logic [31:0] v);
    return (a == 12'h305) ? (v & ~32'h2) : v;
  endfunction

  // CSR file stub
  logic [31:0] csr_mem [4096];
  logic [31:0] ref_mem [4096];
  assign csr_read_value_in = csr_mem[csr_out];

  always @(posedge clk)
    if (csr_write_out)
      case (csr_write_op_out)
        2'b00:   csr_mem[csr_out] <= warl(csr_out, csr_rs1_value_out);
        2'b01:   csr_mem[csr_out] <= warl(csr_out, csr_mem[csr_out] | csr_rs1_value_out);
        2'b10:   csr_mem[csr_out] <= warl(csr_out, csr_mem[csr_out] & ~csr_rs1_value_out);
        default: csr_mem[csr_out] <= csr_mem[csr_out];
      endcase

  // Transaction model and per-cycle compare
  bit          pend = 0;
  logic [1:0]  p_op;
  logic [11:0] p_csr;
  logic [31:0] p_data, p_exp_d, p_stored;
  logic [1:0]  p_exp_e;
  bit          p_ro, p_busy;
  int          p_nacc, n_acc, p_acc_cyc, p_first_v, p_strb;
  int          cyc = 0, acc_cnt = 0, done_cnt = 0;
  logic [31:0] last_d;
  logic [1:0]  last_e;
  int          last_lat, last_strb;

  always @(negedge clk) begin
    logic [31:0] old, nv;
    cyc++;
    if (!reset_n) begin
      chk("reset_outputs", 64'({cmd_ready_out, rsp_valid_out, csr_read_out, csr_write_out,
                               rsp_error_out, rsp_data_out}), 64'(0));
      pend = 0;
    end else begin
      if (cmd_ready_out && rsp_valid_out) chk("ready_and_valid", 64'(1), 64'(0));
      if (csr_busy_in && (csr_read_out || csr_write_out)) chk("strobe_while_busy", 64'(1), 64'(0));
      if (csr_read_out || csr_write_out) begin
        if (!pend || p_ro) chk("stray_strobe", 64'(1), 64'(0));
        else begin
          chk("strobe_read", 64'(csr_read_out), 64'(1));
          chk("strobe_write", 64'(csr_write_out), 64'(n_acc == 0 && p_op != 2'b00));
          chk("strobe_addr", 64'(csr_out), 64'(p_csr));
          chk("strobe_src_imm", 64'({csr_src_out, csr_imm_value_out}), 64'({1'b1, 32'd0}));
          if (csr_write_out) begin
            chk("strobe_rs1", 64'(csr_rs1_value_out), 64'(p_data));
            chk("strobe_wop", 64'(csr_write_op_out), 64'(p_op - 2'd1));
          end
          if (n_acc == 0) p_strb = cyc - p_acc_cyc;
          n_acc++;
        end
      end
      if (pend && csr_busy_in) p_busy = 1;
      if (rsp_valid_out) begin
        if (!pend) chk("stray_response", 64'(1), 64'(0));
        else begin
          if (p_first_v < 0) p_first_v = cyc;
          chk("rsp_data", 64'(rsp_data_out), 64'(p_exp_d));
          chk("rsp_error", 64'(rsp_error_out), 64'(p_exp_e));
          if (rsp_ready_in) begin
            chk("access_count", 64'(n_acc), 64'(p_nacc));
            if (!p_ro && p_op != 2'b00) ref_mem[p_csr] = p_stored;
            chk("file_content", 64'(csr_mem[p_csr]), 64'(ref_mem[p_csr]));
            last_d = rsp_data_out; last_e = rsp_error_out;
            last_lat = p_busy ? -1 : p_first_v - p_acc_cyc;
            last_strb = p_strb;
            pend = 0;
            done_cnt++;
          end
        end
      end
      // Handshake completes at the coming rising edge.
      if (cmd_valid_in && cmd_ready_out) begin
        old = ref_mem[cmd_csr_in];
        case (cmd_op_in)
          2'b01:   nv = cmd_data_in;
          2'b10:   nv = old | cmd_data_in;
          2'b11:   nv = old & ~cmd_data_in;
          default: nv = old;
        endcase
        p_op = cmd_op_in; p_csr = cmd_csr_in; p_data = cmd_data_in;
        p_ro = (cmd_op_in != 2'b00) && (cmd_csr_in[11:10] == 2'b11);
        p_stored = warl(cmd_csr_in, nv);
        p_exp_d = p_ro ? 32'd0 : old;
        p_exp_e = p_ro ? 2'b01 : ((VER && cmd_op_in != 2'b00 && p_stored != nv) ? 2'b10 : 2'b00);
        p_nacc = p_ro ? 0 : ((VER && cmd_op_in != 2'b00) ? 2 : 1);
        n_acc = 0; p_acc_cyc = cyc; p_first_v = -1; p_strb = -1; p_busy = 0;
        pend = 1;
        acc_cnt++;
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                         input int busy_n, input logic [31:0] ed, input logic [1:0] ee,
                         input int elat, input int estrb, input string nm);
    int a0 = acc_cnt;
    int d0 = done_cnt;
    int t = 0;
    cmd_op_in = op; cmd_csr_in = a; cmd_data_in = d;
    cmd_valid_in = 1; rsp_ready_in = 1; csr_busy_in = 0;
    while (acc_cnt == a0 && t < 50) begin @(posedge clk); #1; t++; end
    cmd_valid_in = 0;
    if (busy_n > 0) begin
      csr_busy_in = 1;
      repeat (busy_n) begin @(posedge clk); #1; end
      csr_busy_in = 0;
    end
    t = 0;
    while (done_cnt == d0 && t < 50) begin @(posedge clk); #1; t++; end
    chk({nm, "_done"}, 64'(done_cnt != d0), 64'(1));
    chk({nm, "_data"}, 64'(last_d), 64'(ed));
    chk({nm, "_err"}, 64'(last_e), 64'(ee));
    chk({nm, "_strobe_cycle"}, 64'(last_strb), 64'(estrb));
    if (busy_n == 0) chk({nm, "_latency"}, 64'(last_lat), 64'(elat));
  endtask

  logic [11:0] addrs [8] = '{12'h340, 12'h300, 12'h305, 12'h341,
                             12'hC00, 12'hC80, 12'hF11, 12'h7C0};

  initial begin
    int a0, d0, t, last_acc;
    for (int i = 0; i < 4096; i++) begin
      logic [31:0] v;
      v = $urandom;
      csr_mem[i] <= v;
      ref_mem[i] = v;
    end
    csr_mem[12'h340] <= 32'hDEADBEEF; ref_mem[12'h340] = 32'hDEADBEEF;
    csr_mem[12'h300] <= 32'h0000_1800; ref_mem[12'h300] = 32'h0000_1800;
    csr_mem[12'h305] <= 32'h0;        ref_mem[12'h305] = 32'h0;
    csr_mem[12'h341] <= 32'h0000_1234; ref_mem[12'h341] = 32'h0000_1234;

    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk); #1;

    run_cmd(2'b00, 12'h340, 32'h0, 0, 32'hDEADBEEF, 2'b00, 2, 1, "read_mscratch");
    run_cmd(2'b01, 12'h340, 32'h12345678, 3, 32'hDEADBEEF, 2'b00, 0, 4, "write_busy");
    run_cmd(2'b00, 12'h340, 32'h0, 0, 32'h12345678, 2'b00, 2, 1, "readback_mscratch");
    run_cmd(2'b10, 12'h300, 32'h88, 0, 32'h1800, 2'b00, VER ? 3 : 2, 1, "set_mstatus");
    run_cmd(2'b00, 12'h300, 32'h0, 0, 32'h1888, 2'b00, 2, 1, "readback_mstatus");
    run_cmd(2'b01, 12'h305, 32'hFFFFFFFF, 0, 32'h0, VER ? 2'b10 : 2'b00, VER ? 3 : 2, 1, "write_mtvec");
    run_cmd(2'b00, 12'h305, 32'h0, 0, 32'hFFFFFFFD, 2'b00, 2, 1, "readback_mtvec");
    run_cmd(2'b01, 12'hC00, 32'h55, 0, 32'h0, 2'b01, 1, -1, "write_cycle_ro");
    run_cmd(2'b00, 12'hC00, 32'h0, 0, ref_mem[12'hC00], 2'b00, 2, 1, "read_cycle");
    run_cmd(2'b11, 12'h340, 32'hFF, 0, 32'h12345678, 2'b00, VER ? 3 : 2, 1, "clear_mscratch");
    run_cmd(2'b00, 12'h340, 32'h0, 0, 32'h12345600, 2'b00, 2, 1, "readback_clear");

    // Reset while the command is stuck in ISSUE behind a busy pipeline.
    a0 = acc_cnt; t = 0;
    cmd_op_in = 2'b01; cmd_csr_in = 12'h341; cmd_data_in = 32'hAAAA5555;
    cmd_valid_in = 1; csr_busy_in = 1;
    while (acc_cnt == a0 && t < 50) begin @(posedge clk); #1; t++; end
    cmd_valid_in = 0;
    @(posedge clk); #1;
    d0 = done_cnt;
    reset_n = 0;
    repeat (3) begin @(posedge clk); #1; end
    csr_busy_in = 0;
    reset_n = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_abandon", 64'(done_cnt), 64'(d0));
    run_cmd(2'b00, 12'h341, 32'h0, 0, 32'h1234, 2'b00, 2, 1, "after_reset_read");

    // Randomized traffic: random busy, backpressure and commands.
    d0 = done_cnt;
    last_acc = acc_cnt;
    repeat (3000) begin
      @(posedge clk); #1;
      csr_busy_in  = ($urandom % 4) == 0;
      rsp_ready_in = 1'($urandom);
      if (cmd_valid_in && acc_cnt != last_acc) begin
        cmd_valid_in = 0;
        last_acc = acc_cnt;
      end
      if (!cmd_valid_in && ($urandom % 3) == 0) begin
        cmd_valid_in = 1;
        cmd_op_in    = 2'($urandom);
        cmd_csr_in   = addrs[$urandom % 8];
        cmd_data_in  = $urandom;
      end
    end
    cmd_valid_in = 0; csr_busy_in = 0; rsp_ready_in = 1;
    repeat (20) begin @(posedge clk); #1; end
    chk("drain_idle", 64'(pend), 64'(0));
    chk("random_progress", 64'(done_cnt - d0 > 50), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
